// File: rtl/sel_pkg.sv
// sel_pkg: shared constants and state/direction types for channel_selector.
package sel_pkg;
  localparam int SOLD_OUT = 0;
  typedef enum logic {IDLE, SEARCH} sel_state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} sel_dir_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: tick-sampled saturating debouncer emitting a one-clk press pulse.
// Hold-to-repeat pulses are added when SEL_AUTOREPEAT_EN is defined.
module btn_debounce #(
  parameter int DB_LEN   = 8,
  parameter int REP_DLY  = 64,
  parameter int REP_RATE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DB_LEN + 1);
  logic [CW-1:0] cnt_q;
  logic sat, rep_hit;
  assign sat = cnt_q == CW'(DB_LEN);
`ifdef SEL_AUTOREPEAT_EN
  localparam int RW = $clog2(REP_DLY + REP_RATE + 1);
  logic [RW-1:0] rep_q, rep_n;
  assign rep_n = rep_q + 1'b1;
  assign rep_hit = rep_n == RW'(REP_DLY) || rep_n == RW'(REP_DLY + REP_RATE);
  // after the first repeat the counter folds back to REP_DLY so it fires every REP_RATE ticks
  always_ff @(posedge clk)
    if (!reset) rep_q <= '0;
    else if (tick) rep_q <= !(btn && sat) ? '0 : rep_n == RW'(REP_DLY + REP_RATE) ? RW'(REP_DLY) : rep_n;
`else
  assign rep_hit = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      cnt_q <= '0;
      press <= 1'b0;
    end else begin
      press <= tick && btn && (cnt_q == CW'(DB_LEN - 1) || (sat && rep_hit));
      if (tick) cnt_q <= !btn ? '0 : sat ? cnt_q : cnt_q + 1'b1;
    end
endmodule

// File: rtl/channel_selector.sv
// channel_selector: debounced up/down channel stepping with a one-probe-per-cycle stock search.
// Define SEL_AUTOREPEAT_EN to enable button auto-repeat in the debouncers.
module channel_selector import sel_pkg::*; #(
  parameter int NUM_CH   = 12,
  parameter int CH_W     = $clog2(NUM_CH + 1),
  parameter int DIV      = 1048576,
  parameter int DB_LEN   = 8,
  parameter int REP_DLY  = 64,
  parameter int REP_RATE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  input  logic [NUM_CH-1:0] stock,
  output logic [CH_W-1:0]   sel,
  output logic              busy,
  output logic              moved
);
  localparam int DW = $clog2(DIV);
  logic [DW-1:0] div_q;
  logic tick, up_p, dn_p, go_up, go_dn, skip, recover;
  sel_state_t state_q;
  sel_dir_t dir_q;
  logic [CH_W-1:0] cand_q, probes_q;
  function automatic logic [CH_W-1:0] inc(input logic [CH_W-1:0] x);
    return x == CH_W'(NUM_CH) ? CH_W'(1) : x + 1'b1;
  endfunction
  function automatic logic [CH_W-1:0] dec(input logic [CH_W-1:0] x);
    return x <= CH_W'(1) ? CH_W'(NUM_CH) : x - 1'b1;
  endfunction
  assign tick = div_q == DW'(DIV - 1);
  always_ff @(posedge clk)
    if (!reset) div_q <= '0;
    else div_q <= tick ? '0 : div_q + 1'b1;
  btn_debounce #(.DB_LEN(DB_LEN), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)) u_up (
    .clk(clk), .reset(reset), .tick(tick), .btn(up), .press(up_p));
  btn_debounce #(.DB_LEN(DB_LEN), .REP_DLY(REP_DLY), .REP_RATE(REP_RATE)) u_dn (
    .clk(clk), .reset(reset), .tick(tick), .btn(down), .press(dn_p));
  // simultaneous presses cancel each other
  assign go_up   = enable && up_p && !dn_p;
  assign go_dn   = enable && dn_p && !up_p;
  assign skip    = enable && sel != CH_W'(SOLD_OUT) && !stock[sel - 1'b1];
  assign recover = enable && sel == CH_W'(SOLD_OUT) && |stock;
  always_ff @(posedge clk)
    if (!reset) begin
      state_q  <= IDLE;
      dir_q    <= DIR_UP;
      cand_q   <= '0;
      probes_q <= '0;
      sel      <= CH_W'(1);
      busy     <= 1'b0;
      moved    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (state_q == IDLE) begin
        // skip and recovery both step upward; inc(SOLD_OUT) lands on channel 1
        if (go_up || go_dn || skip || recover) begin
          state_q  <= SEARCH;
          busy     <= 1'b1;
          probes_q <= CH_W'(1);
          dir_q    <= go_dn ? DIR_DOWN : DIR_UP;
          cand_q   <= go_dn ? dec(sel) : inc(sel);
        end
      end else if (stock[cand_q - 1'b1]) begin
        sel     <= cand_q;
        moved   <= cand_q != sel;
        state_q <= IDLE;
        busy    <= 1'b0;
      end else if (probes_q == CH_W'(NUM_CH)) begin
        sel     <= CH_W'(SOLD_OUT);
        moved   <= sel != CH_W'(SOLD_OUT);
        state_q <= IDLE;
        busy    <= 1'b0;
      end else begin
        cand_q   <= dir_q == DIR_UP ? inc(cand_q) : dec(cand_q);
        probes_q <= probes_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_channel_selector.sv
// tb_channel_selector: directed and randomized checks of channel_selector against a search-level model.
module tb_channel_selector;
  localparam int N = 12, DIV = 4, DB = 3, CW = 4;
  logic clk = 1'b0, reset = 1'b0, enable = 1'b1, up = 1'b0, down = 1'b0;
  logic [N-1:0] stock = '1;
  logic [CW-1:0] sel;
  logic busy, moved;
  int n_chk = 0, n_fail = 0, busy_cnt = 0, moved_cnt = 0, m_sel = 1;

  always #5 clk = ~clk;

  channel_selector #(.NUM_CH(N), .CH_W(CW), .DIV(DIV), .DB_LEN(DB), .REP_DLY(4), .REP_RATE(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .down(down),
    .stock(stock), .sel(sel), .busy(busy), .moved(moved));

  always @(posedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (moved === 1'b1) moved_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // channel reached by one step in a ring of N channels numbered 1..N
  function automatic int step(input int c, input bit dn);
    return dn ? (c + N - 2) % N + 1 : c % N + 1;
  endfunction

  task automatic search(input int from, input bit dn, output int res, output int k);
    int c = from;
    res = 0;
    k = N;
    for (int i = 1; i <= N; i++) begin
      c = step(c, dn);
      if (c >= 1 && stock[c-1]) begin
        res = c;
        k = i;
        return;
      end
    end
  endtask

  task automatic auto_model(output int res, output int k);
    if (!enable) begin res = m_sel; k = 0; end
    else if (m_sel != 0 && !stock[m_sel-1]) search(m_sel, 1'b0, res, k);
    else if (m_sel == 0 && |stock) search(0, 1'b0, res, k);
    else begin res = m_sel; k = 0; end
  endtask

  task automatic clr();
    busy_cnt = 0;
    moved_cnt = 0;
  endtask

  task automatic settle();
    repeat (2 * N) @(negedge clk);
  endtask

  task automatic expect_res(input string tag, input int res, input int k);
    check({tag, "_sel"}, sel, res);
    check({tag, "_moved"}, moved_cnt, res != m_sel);
    check({tag, "_busy"}, busy_cnt, k);
    m_sel = res;
  endtask

  task automatic hold(input bit u, input bit d, input int cyc);
    @(negedge clk);
    up = u;
    down = d;
    repeat (cyc) @(negedge clk);
    up = 1'b0;
    down = 1'b0;
  endtask

  task automatic do_press(input string tag, input bit dn);
    int res, k;
    clr();
    hold(!dn, dn, DB * DIV);
    settle();
    if (enable) search(m_sel, dn, res, k);
    else begin res = m_sel; k = 0; end
    expect_res(tag, res, k);
  endtask

  task automatic set_stock(input string tag, input logic [N-1:0] s);
    int res, k;
    clr();
    @(negedge clk);
    stock = s;
    settle();
    auto_model(res, k);
    expect_res(tag, res, k);
  endtask

  task automatic set_en(input string tag, input bit e);
    int res, k;
    clr();
    @(negedge clk);
    enable = e;
    settle();
    auto_model(res, k);
    expect_res(tag, res, k);
  endtask

  initial begin
    int res, k, old;
    repeat (5) @(negedge clk);
    check("rst_sel", sel, 1);
    check("rst_busy", busy, 0);
    check("rst_moved", moved, 0);
    reset = 1'b1;
    clr();
    repeat (100) @(negedge clk);
    check("idle_sel", sel, 1);
    check("idle_moved", moved_cnt, 0);
    check("idle_busy", busy_cnt, 0);

    do_press("dn_wrap", 1'b1);
    do_press("up_wrap", 1'b0);
    set_stock("stk_ff9", 12'hFF9);
    do_press("up_skip2", 1'b0);
    set_stock("autoskip", 12'hFF1);
    set_stock("soldout", 12'h000);
    set_stock("recover", 12'h040);
    set_stock("restock", 12'hFFF);

    clr();
    hold(1'b1, 1'b0, 2 * DIV);
    settle();
    expect_res("short_press", m_sel, 0);
    clr();
    hold(1'b1, 1'b1, DB * DIV);
    settle();
    expect_res("both_press", m_sel, 0);
    set_en("en_off", 1'b0);
    do_press("press_disabled", 1'b0);
    set_stock("skip_disabled", 12'hFBF);
    set_en("en_on_skip", 1'b1);
    set_stock("only_ch1", 12'h001);
    do_press("only_current", 1'b0);

    // reset while a long search is in flight
    clr();
    @(negedge clk);
    stock = 12'h800;
    repeat (3) @(negedge clk);
    check("mid_search_busy", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_abort_sel", sel, 1);
    check("rst_abort_busy", busy, 0);
    reset = 1'b1;
    m_sel = 1;
    clr();
    settle();
    auto_model(res, k);
    expect_res("post_rst_skip", res, k);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: set_stock("rnd_stock", N'($urandom));
        1: do_press("rnd_up", 1'b0);
        2: do_press("rnd_dn", 1'b1);
        default: set_stock("rnd_sparse", N'($urandom & $urandom & $urandom));
      endcase
    end

`ifdef SEL_AUTOREPEAT_EN
    set_stock("rep_stock", 12'hFFF);
    old = m_sel;
    clr();
    hold(1'b1, 1'b0, 20 * DIV);
    settle();
    check("rep_sel", sel, (old - 1 + 8) % N + 1);
    check("rep_moved", moved_cnt, 8);
    check("rep_busy", busy_cnt, 8);
    m_sel = (old - 1 + 8) % N + 1;
`else
    old = m_sel;
    clr();
    hold(1'b1, 1'b0, 20 * DIV);
    settle();
    search(old, 1'b0, res, k);
    expect_res("long_hold_single", res, k);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/channel_selector.md
# channel_selector

Parametrised product-channel selector for the vending front panel. Debounces the up/down buttons on a divided tick, steps a selected-channel index with wrap-around, and skips channels whose stock bit is clear via a one-probe-per-cycle search. Its output drives the display and dispense path with the selected channel, or SOLD_OUT (0) when no channel has stock.

## Interface
- NUM_CH, 12: number of channels, numbered 1..NUM_CH; NUM_CH ≥ 2.
- CH_W, $clog2(NUM_CH+1): width of the index; value 0 means SOLD_OUT.
- DIV, 1048576: clk cycles per sample tick; DIV ≥ 2.
- DB_LEN, 8: consecutive high tick-samples needed to accept a press; DB_LEN ≥ 1.
- REP_DLY, 64: ticks held before the first auto-repeat.
- REP_RATE, 16: ticks between auto-repeats.
- clk  in  1  system clock; one clock only.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  high: presses and auto-skip are accepted.
- up  in  1  raw button level; moves to the next channel.
- down  in  1  raw button level; moves to the previous channel.
- stock  in  NUM_CH  bit i high means channel i+1 has stock.
- sel  out  CH_W  selected channel 1..NUM_CH, or 0 for SOLD_OUT.
- busy  out  1  high while in SEARCH.
- moved  out  1  one-cycle pulse when sel changes.

## Operation
**Tick**
- Divider counts 0..DIV-1.
- tick is high for one clk cycle when the count equals DIV-1.

**Debounce (per button)**
- Sample the level on tick.
- Saturating counter runs up to DB_LEN; a low sample clears it.
- A one-clk press pulse fires on the tick the counter reaches DB_LEN.
- Counter stays saturated while held; no further pulses unless auto-repeat is compiled in.

**Press qualification**
- up_p and down_p asserted in the same cycle: both are discarded.
- Presses are discarded when enable=0 or state=SEARCH. They are not queued.

**FSM**
- States: IDLE and SEARCH. Registers: cand (CH_W bits), dir (1 bit), probes (CH_W bits).
- IDLE, qualified up: cand=inc(sel), dir=up, probes=1, go to SEARCH.
- IDLE, qualified down: cand=dec(sel), dir=down, probes=1, go to SEARCH.
- IDLE, auto-skip (enable=1, sel≠0, stock[sel-1]=0): same as up.
- IDLE, recovery (enable=1, sel=0, |stock=1): cand=1, dir=up, probes=1, go to SEARCH.
- inc(x) = x==NUM_CH ? 1 : x+1. dec(x) = x==1 ? NUM_CH : x-1.
- SEARCH, per cycle:
  - If stock[cand-1]=1: sel←cand, moved=1 if cand≠sel, go to IDLE.
  - Else if probes==NUM_CH: sel←0, moved=1 if sel≠0, go to IDLE.
  - Else: cand←inc/dec(cand) per dir, probes←probes+1.
- stock is sampled live on each probe. If stock changes mid-search, the search does not restart.
- enable falling during SEARCH: the search completes normally.

## Timing
- All outputs are registered.
- Reset values: sel=1, busy=0, moved=0. Internal: state=IDLE, divider=0, debounce and repeat counters=0.
- Reset takes priority over everything, including a search in progress.
- Raw press to press pulse: DB_LEN ticks (first high sample counts as 1).
- Press pulse to sel update: k+1 clk cycles, where k is the number of probes (1..NUM_CH).
  - sel and moved change on the same edge that returns the FSM to IDLE.
- busy is high from the cycle after acceptance through the final probe cycle.
- Auto-skip and recovery start one cycle after their condition is seen in IDLE.
- Only current channel stocked, then a press: sel is unchanged after NUM_CH probes, moved=0.

## Configuration
- SEL_AUTOREPEAT_EN defined:
  - While a button is held and saturated, a repeat counter runs on tick.
  - First extra press pulse after REP_DLY ticks, then one every REP_RATE ticks.
  - Releasing the button clears the repeat counter.
  - Repeat pulses follow the same qualification rules as ordinary presses.
- SEL_AUTOREPEAT_EN undefined: exactly one pulse per press; no repeat logic is synthesised.

## Structure
- Package sel_pkg holds:
  - localparam SOLD_OUT = '0.
  - typedef enum {IDLE, SEARCH} sel_state_t.
  - typedef enum {DIR_UP, DIR_DOWN} sel_dir_t.
- Sub-module btn_debounce:
  - Parameters DB_LEN, REP_DLY, REP_RATE.
  - Ports clk, reset, tick, btn, press.
  - Instantiated twice; holds the SEL_AUTOREPEAT_EN logic.

## Test plan
All scenarios use NUM_CH=12, DIV=4, DB_LEN=3.
1. Reset with stock=12'hFFF -> sel=1, busy=0, moved=0, no movement for 100 cycles.
2. stock all 1, sel=12, up held 3 ticks -> sel=1 two cycles after the press pulse, one moved pulse. Then down -> sel=12.
3. sel=1, stock=12'hFF9 (channels 2 and 3 empty), up -> busy for 3 cycles, sel=4.
4. Clear stock bit 3 while sel=4 -> auto-skip to sel=5. Set stock=0 -> sel=0 after 12 probes. Set stock bit 6 -> recovery gives sel=7.
5. up high for 2 ticks only -> no press, sel unchanged. up and down press pulses coincide -> sel unchanged.
6. SEL_AUTOREPEAT_EN defined, REP_DLY=4, REP_RATE=2, up held 20 ticks -> 1 + 7 press pulses, sel advances by 8 with wrap.
